// File: rtl/fp_ci_pkg.sv
// Shared definitions for the float-unit custom-instruction initiator and
// the fabric logic that builds commands for it.
package fp_ci_pkg;

  localparam int CI_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RECOVER,
    ST_RESP
  } ci_state_t;

  // Multi-cycle opcodes understood by the float unit
  localparam logic [2:0] FP_N_MUL  = 3'd0;
  localparam logic [2:0] FP_N_ADD  = 3'd1;
  localparam logic [2:0] FP_N_SUB  = 3'd2;
  localparam logic [2:0] FP_N_DIV  = 3'd3;
  localparam logic [2:0] FP_N_SQRT = 3'd4;
  localparam logic [2:0] FP_N_I2F  = 3'd5;
  localparam logic [2:0] FP_N_F2I  = 3'd6;

endpackage

// File: rtl/fp_ci_master.sv
// Initiator for the float unit's multi-cycle custom-instruction port: takes one
// command at a time, waits for ci_done under a watchdog, and returns the result.
module fp_ci_master
  import fp_ci_pkg::*;
#(
  parameter int N_W        = 3,
  parameter int TIMEOUT    = 255,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [N_W-1:0]       cmd_n,
  input  logic [CI_DATA_W-1:0] cmd_dataa,
  input  logic [CI_DATA_W-1:0] cmd_datab,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CI_DATA_W-1:0] rsp_result,
  output logic                 rsp_timeout,
  output logic                 ci_clk_en,
  output logic                 ci_reset_req,
  output logic                 ci_start,
  output logic [N_W-1:0]       ci_n,
  output logic [CI_DATA_W-1:0] ci_dataa,
  output logic [CI_DATA_W-1:0] ci_datab,
  input  logic                 ci_done,
  input  logic [CI_DATA_W-1:0] ci_result,
  output logic                 busy,
  output logic                 stray_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  ci_state_t        state;
  logic [CNT_W-1:0] wd_cnt;
  logic [RC_W-1:0]  rc_cnt;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      wd_cnt       <= '0;
      rc_cnt       <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_timeout  <= 1'b0;
      ci_clk_en    <= 1'b0;
      ci_reset_req <= 1'b0;
      ci_start     <= 1'b0;
      ci_n         <= '0;
      ci_dataa     <= '0;
      ci_datab     <= '0;
      stray_done   <= 1'b0;
    end else begin
      ci_clk_en <= 1'b1;
      // Only WAIT expects a completion; anything else is a protocol slip
      if (ci_done && (state != ST_WAIT)) begin
        stray_done <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            ci_n     <= cmd_n;
            ci_dataa <= cmd_dataa;
            ci_datab <= cmd_datab;
            ci_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ci_start <= 1'b0;
          wd_cnt   <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          // A completion in the expiry cycle still counts as a normal answer
          if (ci_done) begin
            rsp_result  <= ci_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 2)) begin
            ci_reset_req <= 1'b1;
            rc_cnt       <= '0;
            state        <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          rc_cnt <= rc_cnt + RC_W'(1);
          if (rc_cnt == RC_W'(RST_CYCLES - 1)) begin
            ci_reset_req <= 1'b0;
            rsp_result   <= '0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_ci_master.sv
// Directed bench for fp_ci_master with a small watchdog (TIMEOUT=16, RST_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fp_ci_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_n;
  logic [31:0] cmd_dataa;
  logic [31:0] cmd_datab;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic        ci_clk_en;
  logic        ci_reset_req;
  logic        ci_start;
  logic [2:0]  ci_n;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        busy;
  logic        stray_done;

  int checks = 0;
  int errors = 0;

  fp_ci_master #(.N_W(3), .TIMEOUT(16), .RST_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n),
    .cmd_dataa(cmd_dataa), .cmd_datab(cmd_datab),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout), .ci_clk_en(ci_clk_en), .ci_reset_req(ci_reset_req),
    .ci_start(ci_start), .ci_n(ci_n), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_done(ci_done), .ci_result(ci_result), .busy(busy), .stray_done(stray_done)
  );

  always #5 clk = ~clk;

  task automatic send_cmd(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1; cmd_n = n; cmd_dataa = a; cmd_datab = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 0; cmd_n = 0; cmd_dataa = 0; cmd_datab = 0;
    rsp_ready = 0; ci_done = 0; ci_result = 0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result, rsp_timeout, ci_clk_en, ci_reset_req, ci_start,
         ci_n, ci_dataa, ci_datab, busy, stray_done} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got nonzero, required all zero");
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ci_clk_en !== 1'b1) begin errors++; $display("[TB] FAIL clk_en_after_reset: got %b required 1", ci_clk_en); end
  endtask

  task automatic test_basic();
    int starts;
    logic early;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_cmd_ready: got %b required 1", cmd_ready); end
    send_cmd(3'd1, 32'h3F800000, 32'h40000000);
    checks++;
    if ({ci_start, ci_n, ci_dataa, ci_datab, busy, cmd_ready} !== {1'b1, 3'd1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_issue: got start=%b n=%0d a=%h b=%h busy=%b rdy=%b required 1 1 3f800000 40000000 1 0",
               ci_start, ci_n, ci_dataa, ci_datab, busy, cmd_ready);
    end
    starts = 1; early = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (ci_start) starts++;
      if (rsp_valid) early = 1'b1;
      if (k == 5) begin ci_done = 1'b1; ci_result = 32'h40400000; end
    end
    @(negedge clk);
    ci_done = 1'b0; ci_result = 32'h0;
    checks++;
    if ({rsp_valid, rsp_result, rsp_timeout} !== {1'b1, 32'h40400000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_resp: got v=%b r=%h to=%b required 1 40400000 0", rsp_valid, rsp_result, rsp_timeout);
    end
    checks++;
    if (starts !== 1 || early !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_start_count: got starts=%0d early=%b required 1 0", starts, early);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_handshake: got v=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(3'd2, 32'h11111111, 32'h22222222);
    @(negedge clk);
    ci_done = 1'b1; ci_result = 32'hCAFEF00D;
    @(negedge clk);
    ci_done = 1'b0;
    cmd_valid = 1'b1; cmd_n = 3'd3; cmd_dataa = 32'hAAAA5555; cmd_datab = 32'h5555AAAA;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({rsp_valid, rsp_result, rsp_timeout, cmd_ready, ci_start} !== {1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL stall_cycle_%0d: got v=%b r=%h to=%b rdy=%b st=%b required 1 cafef00d 0 0 0",
                 k, rsp_valid, rsp_result, rsp_timeout, cmd_ready, ci_start);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, ci_start, rsp_valid} !== 3'b100) begin
      errors++; $display("[TB] FAIL after_handshake: got rdy=%b st=%b v=%b required 1 0 0", cmd_ready, ci_start, rsp_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({ci_start, ci_n, ci_dataa, ci_datab} !== {1'b1, 3'd3, 32'hAAAA5555, 32'h5555AAAA}) begin
      errors++;
      $display("[TB] FAIL second_issue: got st=%b n=%0d a=%h b=%h required 1 3 aaaa5555 5555aaaa", ci_start, ci_n, ci_dataa, ci_datab);
    end
    @(negedge clk);
    ci_done = 1'b1; ci_result = 32'h0BADBEEF;
    @(negedge clk);
    ci_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_result} !== {1'b1, 32'h0BADBEEF}) begin
      errors++; $display("[TB] FAIL second_resp: got v=%b r=%h required 1 0badbeef", rsp_valid, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    send_cmd(3'd4, 32'h00000001, 32'h00000002);
    checks++;
    if (ci_start !== 1'b1) begin errors++; $display("[TB] FAIL timeout_start: got %b required 1", ci_start); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({ci_reset_req, rsp_valid} !== {(k >= 16 && k <= 19), (k == 20)}) begin
        errors++;
        $display("[TB] FAIL timeout_cycle_%0d: got req=%b v=%b required %b %b",
                 k, ci_reset_req, rsp_valid, (k >= 16 && k <= 19), (k == 20));
      end
    end
    checks++;
    if ({rsp_timeout, rsp_result} !== {1'b1, 32'h0}) begin
      errors++; $display("[TB] FAIL timeout_resp: got to=%b r=%h required 1 00000000", rsp_timeout, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_done_at_expiry();
    logic req_seen;
    send_cmd(3'd0, 32'h3F000000, 32'h3F000000);
    req_seen = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (ci_reset_req) req_seen = 1'b1;
      if (k == 15) begin ci_done = 1'b1; ci_result = 32'h12345678; end
    end
    @(negedge clk);
    ci_done = 1'b0;
    if (ci_reset_req) req_seen = 1'b1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_timeout} !== {1'b1, 32'h12345678, 1'b0}) begin
      errors++;
      $display("[TB] FAIL expiry_resp: got v=%b r=%h to=%b required 1 12345678 0", rsp_valid, rsp_result, rsp_timeout);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ci_reset_req) req_seen = 1'b1;
    end
    checks++;
    if (req_seen !== 1'b0) begin errors++; $display("[TB] FAIL expiry_no_reset_req: got %b required 0", req_seen); end
  endtask

  task automatic test_stray();
    logic bad;
    checks++;
    if (stray_done !== 1'b0) begin errors++; $display("[TB] FAIL stray_before: got %b required 0", stray_done); end
    ci_done = 1'b1; ci_result = 32'hDEADDEAD;
    @(negedge clk);
    ci_done = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!stray_done || rsp_valid || !cmd_ready || busy) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("[TB] FAIL stray_idle: got stray=%b v=%b rdy=%b required sticky 1 0 1", stray_done, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    logic bad;
    send_cmd(3'd1, 32'h40A00000, 32'h40A00000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_timeout, ci_clk_en, ci_reset_req, ci_start,
         ci_n, ci_dataa, ci_datab, busy, stray_done, cmd_ready} !== {{(1+32+1+1+1+1+3+32+32+1+1){1'b0}}, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_in_wait: got v=%b en=%b n=%0d a=%h busy=%b stray=%b rdy=%b required all 0 rdy 1",
               rsp_valid, ci_clk_en, ci_n, ci_dataa, busy, stray_done, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ci_done = 1'b1; ci_result = 32'h41200000;
    @(negedge clk);
    ci_done = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid || busy || !cmd_ready) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("[TB] FAIL late_done_response: got activity, required none"); end
    checks++;
    if (stray_done !== 1'b1) begin errors++; $display("[TB] FAIL late_done_stray: got %b required 1", stray_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_done_at_expiry();
    test_stray();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
